// File: rtl/obi_2to1_arbiter.sv
// Two-master OBI arbiter: round-robin selection with a lock that holds the
// request stable until grant, and an ID FIFO that routes in-order responses.
module obi_2to1_arbiter #(
  parameter int OBI_ADDRW       = 32,
  parameter int OBI_DATAW       = 32,
  parameter int OBI_STRBW       = OBI_DATAW / 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 clk_i,
  input  logic                                 arst_ni,
  input  logic                                 m0_req_i,
  output logic                                 m0_gnt_o,
  input  logic [OBI_ADDRW-1:0]                 m0_addr_i,
  input  logic                                 m0_we_i,
  input  logic [OBI_STRBW-1:0]                 m0_be_i,
  input  logic [OBI_DATAW-1:0]                 m0_wdata_i,
  output logic                                 m0_rvalid_o,
  output logic [OBI_DATAW-1:0]                 m0_rdata_o,
  input  logic                                 m1_req_i,
  output logic                                 m1_gnt_o,
  input  logic [OBI_ADDRW-1:0]                 m1_addr_i,
  input  logic                                 m1_we_i,
  input  logic [OBI_STRBW-1:0]                 m1_be_i,
  input  logic [OBI_DATAW-1:0]                 m1_wdata_i,
  output logic                                 m1_rvalid_o,
  output logic [OBI_DATAW-1:0]                 m1_rdata_o,
  output logic                                 slv_req_o,
  input  logic                                 slv_gnt_i,
  output logic [OBI_ADDRW-1:0]                 slv_addr_o,
  output logic                                 slv_we_o,
  output logic [OBI_STRBW-1:0]                 slv_be_o,
  output logic [OBI_DATAW-1:0]                 slv_wdata_o,
  input  logic                                 slv_rvalid_i,
  input  logic [OBI_DATAW-1:0]                 slv_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                 err_o
);

  localparam int PTRW = $clog2(MAX_OUTSTANDING);
  localparam int CNTW = $clog2(MAX_OUTSTANDING + 1);

  logic                       r_ptr;
  logic                       r_lock;
  logic                       r_lock_sel;
  logic                       r_err;
  logic [MAX_OUTSTANDING-1:0] r_ids;
  logic [PTRW-1:0]            r_head;
  logic [PTRW-1:0]            r_tail;
  logic [CNTW-1:0]            r_count;

  logic w_full;
  logic w_sel;
  logic w_sel_req;
  logic w_push;
  logic w_pop;
  logic w_head_id;

  // A locked selection overrides round-robin until the handshake completes.
  always_comb begin
    w_sel = 1'b0;
    if (r_lock) begin
      w_sel = r_lock_sel;
    end else if (m0_req_i && m1_req_i) begin
      w_sel = r_ptr;
    end else if (m1_req_i) begin
      w_sel = 1'b1;
    end
  end

  assign w_full    = (r_count == CNTW'(MAX_OUTSTANDING));
  assign w_sel_req = w_sel ? m1_req_i : m0_req_i;

  // Full blocks requests even when a pop is pending: no rvalid->gnt path.
  assign slv_req_o   = w_sel_req & ~w_full & arst_ni;
  assign slv_addr_o  = w_sel ? m1_addr_i  : m0_addr_i;
  assign slv_we_o    = w_sel ? m1_we_i    : m0_we_i;
  assign slv_be_o    = w_sel ? m1_be_i    : m0_be_i;
  assign slv_wdata_o = w_sel ? m1_wdata_i : m0_wdata_i;

  assign w_push   = slv_req_o & slv_gnt_i;
  assign m0_gnt_o = w_push & ~w_sel;
  assign m1_gnt_o = w_push &  w_sel;

  // Responses with nothing outstanding are dropped and flagged.
  assign w_pop       = slv_rvalid_i & (r_count != '0);
  assign w_head_id   = r_ids[r_head];
  assign m0_rvalid_o = w_pop & ~w_head_id;
  assign m1_rvalid_o = w_pop &  w_head_id;
  assign m0_rdata_o  = slv_rdata_i;
  assign m1_rdata_o  = slv_rdata_i;

  assign outstanding_o = r_count;
  assign err_o         = r_err;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_ptr      <= 1'b0;
      r_lock     <= 1'b0;
      r_lock_sel <= 1'b0;
      r_err      <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PTRW'(1);
        r_ptr  <= ~w_sel;
        r_lock <= 1'b0;
      end else if (slv_req_o) begin
        r_lock     <= 1'b1;
        r_lock_sel <= w_sel;
      end
      if (w_pop) begin
        r_head <= r_head + PTRW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNTW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNTW'(1);
      end
      if (slv_rvalid_i && (r_count == '0)) begin
        r_err <= 1'b1;
      end
    end
  end

  // ID storage needs no reset: entries are only read behind a valid count.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_ids[r_tail] <= w_sel;
    end
  end

endmodule

// File: tb/tb_obi_2to1_arbiter.sv
// Bench for obi_2to1_arbiter: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model of owners and priority.
module tb_obi_2to1_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SW   = 4;
  localparam int MAXO = 4;
  localparam int CW   = 3;

  logic          clk_i = 1'b0;
  logic          arst_ni = 1'b0;
  logic          m0_req_i, m0_gnt_o, m0_we_i, m0_rvalid_o;
  logic [AW-1:0] m0_addr_i;
  logic [SW-1:0] m0_be_i;
  logic [DW-1:0] m0_wdata_i, m0_rdata_o;
  logic          m1_req_i, m1_gnt_o, m1_we_i, m1_rvalid_o;
  logic [AW-1:0] m1_addr_i;
  logic [SW-1:0] m1_be_i;
  logic [DW-1:0] m1_wdata_i, m1_rdata_o;
  logic          slv_req_o, slv_gnt_i, slv_we_o, slv_rvalid_i;
  logic [AW-1:0] slv_addr_o;
  logic [SW-1:0] slv_be_o;
  logic [DW-1:0] slv_wdata_o, slv_rdata_i;
  logic [CW-1:0] outstanding_o;
  logic          err_o;

  always #5 clk_i = ~clk_i;

  obi_2to1_arbiter #(
    .OBI_ADDRW(AW), .OBI_DATAW(DW), .OBI_STRBW(SW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i(clk_i), .arst_ni(arst_ni),
    .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_addr_i(m0_addr_i),
    .m0_we_i(m0_we_i), .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i),
    .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_addr_i(m1_addr_i),
    .m1_we_i(m1_we_i), .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i),
    .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .slv_req_o(slv_req_o), .slv_gnt_i(slv_gnt_i), .slv_addr_o(slv_addr_o),
    .slv_we_o(slv_we_o), .slv_be_o(slv_be_o), .slv_wdata_o(slv_wdata_o),
    .slv_rvalid_i(slv_rvalid_i), .slv_rdata_i(slv_rdata_i),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: owners of granted transactions in issue order.
  int q_owner[$];
  int mdl_ptr = 0;
  bit mdl_lock = 0;
  int mdl_lock_sel = 0;
  bit mdl_err = 0;
  int e_sel;
  bit e_req, e_hs, e_pop;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_check();
    bit full;
    int s;
    int own;
    full = (q_owner.size() == MAXO);
    if (mdl_lock) s = mdl_lock_sel;
    else if (m0_req_i && m1_req_i) s = mdl_ptr;
    else if (m1_req_i) s = 1;
    else s = 0;
    e_sel = s;
    e_req = ((s == 0) ? m0_req_i : m1_req_i) && !full;
    e_hs  = e_req && slv_gnt_i;
    own   = (q_owner.size() > 0) ? q_owner[0] : -1;
    e_pop = slv_rvalid_i && (q_owner.size() > 0);
    chk("slv_req", 64'(slv_req_o), 64'(e_req));
    chk("m0_gnt", 64'(m0_gnt_o), 64'(e_hs && s == 0));
    chk("m1_gnt", 64'(m1_gnt_o), 64'(e_hs && s == 1));
    chk("m0_rvalid", 64'(m0_rvalid_o), 64'(e_pop && own == 0));
    chk("m1_rvalid", 64'(m1_rvalid_o), 64'(e_pop && own == 1));
    chk("outstanding", 64'(outstanding_o), 64'(q_owner.size()));
    chk("err", 64'(err_o), 64'(mdl_err));
    chk("m0_rdata", 64'(m0_rdata_o), 64'(slv_rdata_i));
    chk("m1_rdata", 64'(m1_rdata_o), 64'(slv_rdata_i));
    if (e_req) begin
      chk("slv_addr", 64'(slv_addr_o), 64'((s != 0) ? m1_addr_i : m0_addr_i));
      chk("slv_we", 64'(slv_we_o), 64'((s != 0) ? m1_we_i : m0_we_i));
      chk("slv_be", 64'(slv_be_o), 64'((s != 0) ? m1_be_i : m0_be_i));
      chk("slv_wdata", 64'(slv_wdata_o), 64'((s != 0) ? m1_wdata_i : m0_wdata_i));
    end
  endtask

  task automatic model_update();
    if (slv_rvalid_i && q_owner.size() == 0) mdl_err = 1;
    if (e_pop) void'(q_owner.pop_front());
    if (e_hs) begin
      q_owner.push_back(e_sel);
      mdl_ptr  = 1 - e_sel;
      mdl_lock = 0;
    end else if (e_req) begin
      mdl_lock     = 1;
      mdl_lock_sel = e_sel;
    end
  endtask

  task automatic settle();
    @(negedge clk_i);
    model_check();
  endtask

  task automatic advance();
    @(posedge clk_i);
    model_update();
    #1;
  endtask

  task automatic idle();
    m0_req_i = 0; m0_addr_i = '0; m0_we_i = 0; m0_be_i = '0; m0_wdata_i = '0;
    m1_req_i = 0; m1_addr_i = '0; m1_we_i = 0; m1_be_i = '0; m1_wdata_i = '0;
    slv_gnt_i = 0; slv_rvalid_i = 0; slv_rdata_i = '0;
  endtask

  task automatic do_reset();
    m0_req_i = 1; m1_req_i = 1; slv_gnt_i = 1; slv_rvalid_i = 1;
    arst_ni = 0;
    #2;
    chk("rst_slv_req", 64'(slv_req_o), 64'(0));
    chk("rst_m0_gnt", 64'(m0_gnt_o), 64'(0));
    chk("rst_m1_gnt", 64'(m1_gnt_o), 64'(0));
    chk("rst_m0_rvalid", 64'(m0_rvalid_o), 64'(0));
    chk("rst_m1_rvalid", 64'(m1_rvalid_o), 64'(0));
    chk("rst_outstanding", 64'(outstanding_o), 64'(0));
    chk("rst_err", 64'(err_o), 64'(0));
    @(posedge clk_i);
    #1;
    idle();
    arst_ni = 1;
    q_owner.delete();
    mdl_ptr = 0; mdl_lock = 0; mdl_lock_sel = 0; mdl_err = 0;
  endtask

  initial begin
    bit g0, g1;
    idle();
    do_reset();

    // Single master: three back-to-back reads, responses two cycles later.
    slv_gnt_i = 1;
    for (int k = 0; k < 5; k++) begin
      m0_req_i = (k < 3); m0_addr_i = 32'(32'h100 + 4 * k); m0_be_i = 4'hF;
      slv_rvalid_i = (k >= 2); slv_rdata_i = 32'(32'hA0 + k - 2);
      settle();
      if (k < 3) chk("s1_m0_gnt", 64'(m0_gnt_o), 64'(1));
      if (k >= 2) begin
        chk("s1_m0_rvalid", 64'(m0_rvalid_o), 64'(1));
        chk("s1_rdata", 64'(m0_rdata_o), 64'(32'hA0 + k - 2));
      end
      chk("s1_m1_rvalid", 64'(m1_rvalid_o), 64'(0));
      if (k == 2) chk("s1_peak", 64'(outstanding_o), 64'(2));
      advance();
    end
    idle();

    // Contention: grants and responses alternate m0,m1,m0,m1.
    do_reset();
    slv_gnt_i = 1;
    for (int k = 0; k < 8; k++) begin
      m0_req_i = (k < 4); m0_addr_i = 32'(32'h1000 + k);
      m1_req_i = (k < 4); m1_addr_i = 32'(32'h2000 + k); m1_we_i = 1;
      m1_wdata_i = 32'(32'hBEEF0000 + k);
      slv_rvalid_i = (k >= 4); slv_rdata_i = 32'(k - 3);
      settle();
      if (k < 4) begin
        chk("s2_m0_gnt", 64'(m0_gnt_o), 64'(k % 2 == 0));
        chk("s2_m1_gnt", 64'(m1_gnt_o), 64'(k % 2 == 1));
      end else begin
        chk("s2_m0_rvalid", 64'(m0_rvalid_o), 64'(k % 2 == 0));
        chk("s2_m1_rvalid", 64'(m1_rvalid_o), 64'(k % 2 == 1));
        chk("s2_rdata", 64'(m0_rdata_o), 64'(k - 3));
      end
      advance();
    end
    idle();

    // Stall: m1 wins after an m0 grant, held 5 cycles while m0 drops out.
    do_reset();
    slv_gnt_i = 1; m0_req_i = 1; m0_addr_i = 32'h200;
    settle(); advance();
    slv_gnt_i = 0; m0_addr_i = 32'h300;
    m1_req_i = 1; m1_addr_i = 32'h400; m1_we_i = 1; m1_wdata_i = 32'h1234; m1_be_i = 4'h3;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) m0_req_i = 0;
      settle();
      chk("s3_addr", 64'(slv_addr_o), 64'(32'h400));
      advance();
    end
    slv_gnt_i = 1;
    settle();
    chk("s3_m1_gnt", 64'(m1_gnt_o), 64'(1));
    advance();
    idle();

    // Lock: m1 alone gets stalled, then m0 joins; pointer would favour m0.
    do_reset();
    m1_req_i = 1; m1_addr_i = 32'h500;
    settle(); advance();
    m0_req_i = 1; m0_addr_i = 32'h600;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("s3b_addr", 64'(slv_addr_o), 64'(32'h500));
      advance();
    end
    slv_gnt_i = 1;
    settle();
    chk("s3b_m1_gnt", 64'(m1_gnt_o), 64'(1));
    chk("s3b_m0_gnt", 64'(m0_gnt_o), 64'(0));
    advance();
    m1_req_i = 0;
    settle();
    chk("s3b_m0_next", 64'(m0_gnt_o), 64'(1));
    advance();
    idle();

    // Full: four grants, fifth blocked until a response frees a slot.
    do_reset();
    slv_gnt_i = 1; m0_req_i = 1;
    for (int k = 0; k < 4; k++) begin
      m0_addr_i = 32'(32'h700 + 4 * k);
      settle();
      chk("s4_m0_gnt", 64'(m0_gnt_o), 64'(1));
      advance();
    end
    m0_addr_i = 32'h710;
    settle();
    chk("s4_full_cnt", 64'(outstanding_o), 64'(4));
    chk("s4_full_req", 64'(slv_req_o), 64'(0));
    chk("s4_full_gnt", 64'(m0_gnt_o), 64'(0));
    advance();
    slv_rvalid_i = 1; slv_rdata_i = 32'h77;
    settle();
    chk("s4_pop_nogrant", 64'(m0_gnt_o), 64'(0));
    chk("s4_pop_rvalid", 64'(m0_rvalid_o), 64'(1));
    advance();
    slv_rvalid_i = 0;
    settle();
    chk("s4_after_cnt", 64'(outstanding_o), 64'(3));
    chk("s4_after_gnt", 64'(m0_gnt_o), 64'(1));
    advance();
    idle();

    // Spurious response, then normal routing with the sticky error set.
    do_reset();
    slv_rvalid_i = 1; slv_rdata_i = 32'hDEAD;
    settle();
    chk("s5_m0_rv", 64'(m0_rvalid_o), 64'(0));
    chk("s5_m1_rv", 64'(m1_rvalid_o), 64'(0));
    advance();
    slv_rvalid_i = 0;
    settle();
    chk("s5_err", 64'(err_o), 64'(1));
    advance();
    m1_req_i = 1; m1_addr_i = 32'h800; slv_gnt_i = 1;
    settle(); chk("s5_m1_gnt", 64'(m1_gnt_o), 64'(1)); advance();
    m1_req_i = 0; slv_gnt_i = 0; slv_rvalid_i = 1; slv_rdata_i = 32'h55;
    settle();
    chk("s5_m1_rv2", 64'(m1_rvalid_o), 64'(1));
    chk("s5_err_sticky", 64'(err_o), 64'(1));
    advance();
    // Push into an empty FIFO while a stray rvalid arrives.
    m0_req_i = 1; m0_addr_i = 32'h900; slv_gnt_i = 1; slv_rvalid_i = 1;
    settle();
    chk("s5_same_m0_rv", 64'(m0_rvalid_o), 64'(0));
    advance();
    m0_req_i = 0; slv_gnt_i = 0;
    settle();
    chk("s5_same_cnt", 64'(outstanding_o), 64'(1));
    chk("s5_drain_m0", 64'(m0_rvalid_o), 64'(1));
    advance();
    slv_rvalid_i = 0;

    // Reset mid-flight: two outstanding, pointer left at m1.
    slv_gnt_i = 1; m1_req_i = 1; m1_addr_i = 32'hA00;
    settle(); advance();
    m1_req_i = 0; m0_req_i = 1; m0_addr_i = 32'hB00;
    settle(); advance();
    m0_req_i = 0; slv_gnt_i = 0;
    settle();
    chk("s6_pre_cnt", 64'(outstanding_o), 64'(2));
    advance();
    do_reset();
    slv_gnt_i = 1; m0_req_i = 1; m1_req_i = 1;
    settle();
    chk("s6_m0_first", 64'(m0_gnt_o), 64'(1));
    chk("s6_m1_not", 64'(m1_gnt_o), 64'(0));
    advance();
    idle();

    // Randomized OBI-compliant traffic.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if (!m0_req_i && $urandom_range(0, 2) == 0) begin
        m0_req_i = 1; m0_addr_i = $urandom; m0_we_i = 1'($urandom_range(0, 1));
        m0_be_i = 4'($urandom); m0_wdata_i = $urandom;
      end
      if (!m1_req_i && $urandom_range(0, 2) == 0) begin
        m1_req_i = 1; m1_addr_i = $urandom; m1_we_i = 1'($urandom_range(0, 1));
        m1_be_i = 4'($urandom); m1_wdata_i = $urandom;
      end
      slv_gnt_i = ($urandom_range(0, 3) != 0);
      if (q_owner.size() > 0) slv_rvalid_i = ($urandom_range(0, 2) == 0);
      else slv_rvalid_i = ($urandom_range(0, 40) == 0);
      slv_rdata_i = $urandom;
      settle();
      g0 = m0_gnt_o;
      g1 = m1_gnt_o;
      advance();
      if (g0) m0_req_i = 0;
      if (g1) m1_req_i = 0;
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/obi_2to1_arbiter.md
Name: obi_2to1_arbiter

Overview:
- Merges two OBI master ports into the single OBI port that feeds obi_2_axi: master 0 is the core instruction fetch, master 1 is core load/store.
- Runs in the OBI clock domain, upstream of obi_2_axi's request CDC FIFO.
- Arbitrates round-robin and holds the request stable until grant.
- Records the owner of every granted transaction in an ID FIFO, so each in-order response is routed back to the master that issued it.

Parameters:
- OBI_ADDRW, 32, address width
- OBI_DATAW, 32, data width
- OBI_STRBW, OBI_DATAW/8, byte-enable width
- MAX_OUTSTANDING, 4, ID FIFO depth = maximum granted-but-unanswered transactions (power of two, >=2)

Ports:
- clk_i  in  1  OBI clock
- arst_ni  in  1  asynchronous active-low reset
- m0_req_i  in  1  master 0 request
- m0_gnt_o  out  1  master 0 grant
- m0_addr_i  in  OBI_ADDRW  master 0 address
- m0_we_i  in  1  master 0 write enable
- m0_be_i  in  OBI_STRBW  master 0 byte enable
- m0_wdata_i  in  OBI_DATAW  master 0 write data
- m0_rvalid_o  out  1  master 0 response valid
- m0_rdata_o  out  OBI_DATAW  master 0 read data
- m1_*: same set as m0_* for master 1
- slv_req_o  out  1  downstream request
- slv_gnt_i  in  1  downstream grant
- slv_addr_o  out  OBI_ADDRW  downstream address
- slv_we_o  out  1  downstream write enable
- slv_be_o  out  OBI_STRBW  downstream byte enable
- slv_wdata_o  out  OBI_DATAW  downstream write data
- slv_rvalid_i  in  1  downstream response valid
- slv_rdata_i  in  OBI_DATAW  downstream read data
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current ID FIFO occupancy
- err_o  out  1  sticky protocol error

Behaviour:
- Reset values (arst_ni low, asynchronous):
  - priority pointer = master 0
  - lock = 0
  - ID FIFO empty, outstanding_o = 0
  - err_o = 0
  - all gnt/rvalid outputs = 0
  - slv_req_o = 0; forced 0 while arst_ni is low
- Full condition: full = (outstanding_o == MAX_OUTSTANDING). While full:
  - slv_req_o = 0
  - no grants are issued
  - a push in the same cycle as a pop is still blocked; no bypass, so there is no combinational rvalid->gnt path
- Selection, combinational, when not locked:
  - only one master requesting: select it
  - both requesting: select the priority pointer
- Lock register:
  - set when slv_req_o=1 and slv_gnt_i=0
  - while set, the selection is frozen, so addr/we/be/wdata stay stable until grant (OBI rule)
  - cleared on the handshake
- Downstream drive:
  - slv_* = selected master's fields
  - slv_req_o = selected req & ~full
- Grant: mX_gnt_o = slv_gnt_i & slv_req_o & (sel==X). Zero added latency; the grant is combinational pass-through.
- On the handshake:
  - push the selected ID (1 bit) into the ID FIFO
  - priority pointer := other master
- Response:
  - on slv_rvalid_i, pop the FIFO head
  - assert m<head>_rvalid_o in the same cycle, combinationally
  - slv_rdata_i is broadcast to both mX_rdata_o
  - the non-head master's rvalid stays 0
  - rvalid is returned for writes as well as reads
- Push and pop in the same cycle (not full): occupancy unchanged; head/tail pointers each advance and wrap modulo MAX_OUTSTANDING.
- rvalid with FIFO empty (including same-cycle push into an empty FIFO):
  - response is dropped; both rvalid outputs = 0
  - err_o set to 1 and held until reset
  - FIFO unchanged
- Reset mid-operation: all outstanding IDs are discarded and the lock is released. Downstream is reset by the same arst_ni.

Test Plan:
- Single master: m0 issues 3 reads, addr 0x100/0x104/0x108, slv_gnt_i tied 1, rdata 0xA0/0xA1/0xA2 returned 2 cycles later.
  -> m0_gnt_o high 3 consecutive cycles
  -> m0_rvalid_o pulses with 0xA0, 0xA1, 0xA2 in order
  -> m1_rvalid_o never asserts; outstanding_o peaks at 2
- Contention: m0 and m1 request continuously, slv_gnt_i=1.
  -> grants alternate m0,m1,m0,m1
  -> responses 0x1,0x2,0x3,0x4 land on m0,m1,m0,m1 respectively
- Stall: both request, slv_gnt_i=0 for 5 cycles, then m0 drops req while m1's selection is locked.
  -> slv_addr_o constant for all 5 cycles
  -> grant goes to the locked master when slv_gnt_i rises
- Full: MAX_OUTSTANDING=4, 4 grants with no rvalid.
  -> outstanding_o=4, slv_req_o=0, no 5th grant
  -> one rvalid brings outstanding_o to 3; the next grant follows one cycle later
- Spurious response: slv_rvalid_i=1 with outstanding_o=0.
  -> both rvalid outputs 0, err_o=1 sticky
  -> subsequent traffic still routed correctly
- Reset mid-flight: 2 outstanding, then arst_ni low for 1 cycle.
  -> outstanding_o=0, err_o=0, priority pointer = master 0
  -> first grant after reset (both requesting) goes to m0
